clk_gate_ctrl: RTL and testbench
================================

// Module: clk_gate_ctrl
// PURPOSE
//  Auto clock-gating controller driving the enable of the clock-gate cell for one gated domain.
//  Runs on the ungated clock and raises the enable on demand from requesters or the domain's busy flag.
//  Grants access only after a settle delay, and drops the enable after a programmable idle window.
//  Sits directly upstream of the clock-gate cell: en_o feeds its en_i; test_en is routed separately.
// PARAMETERS
//  IdleCycles  16  consecutive idle cycles in ON before gating; legal >= 1
//  WakeDelay    2  cycles en_o is high before gnt_o asserts; legal >= 1
//  CntWidth    $clog2(max(IdleCycles,WakeDelay)+1)  shared counter width; derived, not overridable
// PORTS
//  clk_i       in   1  ungated clock
//  rst_ni      in   1  reset; asynchronous, active-low
//  req_i       in   1  a requester needs the gated domain
//  busy_i      in   1  gated domain reports outstanding work
//  force_en_i  in   1  software override; holds the clock running
//  en_o        out  1  clock-gate enable, to gate cell en_i
//  gnt_o       out  1  gated clock running and settled; requesters may use the domain
//  state_o     out  2  FSM state for status CSR: OFF=0 WAKE=1 ON=2 DRAIN=3
// BEHAVIOUR
//  Reset:
//   - async assert forces state OFF, en_o=0, gnt_o=0 and counter=0 immediately, with no clock edge required.
//   - Reset mid-operation stops the gated clock abruptly; the gated domain must share rst_ni.
//  Registered outputs:
//   - en_o and gnt_o are direct flop outputs; no combinational decode reaches the gate cell.
//   - state_o is the state register.
//  Activity: act = req_i | busy_i | force_en_i, sampled on each rising clk_i.
//  OFF   (en=0, gnt=0):
//   - act -> WAKE, counter=0.
//  WAKE  (en=1, gnt=0):
//   - counter increments each cycle.
//   - When counter==WakeDelay-1 -> ON, counter=0.
//   - act is ignored; WAKE always completes.
//  ON    (en=1, gnt=1):
//   - act -> counter=0.
//   - !act and counter==IdleCycles-1 -> DRAIN.
//   - otherwise counter increments.
//  DRAIN (en=1, gnt=0, one cycle only):
//   - act -> ON with counter=0, so en_o never drops.
//   - otherwise -> OFF.
//  Latency:
//   - act first sampled at edge t in OFF gives en_o=1 after edge t, and gnt_o=1 after edge t+WakeDelay.
//  Gating:
//   - gnt_o falls one cycle before en_o, so requesters see the grant withdrawn before the clock stops.
//   - IdleCycles consecutive idle ON cycles are required; any act pulse restarts the count.
//  Counter:
//   - Never wraps; it is cleared on every state change.
//   - The upper bound is guaranteed by the transitions above.
//  force_en_i:
//   - High keeps the FSM out of OFF, and back in ON after any pending wake.
//   - Low resumes normal idle counting from 0.
// TESTING
//  T1 reset: hold rst_ni=0 then release with all inputs 0 for 20 cycles -> en_o=0, gnt_o=0, state_o=0 throughout.
//  T2 wake (IdleCycles=4, WakeDelay=2): req_i=1 sampled at edge 5 -> en_o=1 after edge 5, gnt_o=1 after edge 7, state_o 1 then 2.
//  T3 timeout: from ON drop all act at edge 10 -> state_o=3 after edge 13 (gnt_o=0, en_o=1); after edge 14 state_o=0, en_o=0.
//  T4 restart: busy_i pulse on the 3rd idle cycle -> DRAIN is delayed to exactly 4 idle cycles after the pulse.
//  T5 rescue: req_i=1 during DRAIN -> back to ON next edge; en_o never 0; gnt_o low exactly 1 cycle.
//  T6 force and async reset:
//   - force_en_i=1 with no other act for 100 cycles -> en_o stays 1.
//   - rst_ni pulled low mid-WAKE between edges -> en_o=0 before the next clk_i edge.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// Auto clock-gating controller for one gated domain.
// Raises the gate enable on demand, grants after settling, gates after idling.
module clk_gate_ctrl #(
    parameter int IdleCycles = 16,
    parameter int WakeDelay  = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_i,
    input  logic       busy_i,
    input  logic       force_en_i,
    output logic       en_o,
    output logic       gnt_o,
    output logic [1:0] state_o
);

    localparam int MaxCnt   = (IdleCycles > WakeDelay) ? IdleCycles : WakeDelay;
    localparam int CntWidth = $clog2(MaxCnt + 1);

    localparam logic [CntWidth-1:0] WakeLast = CntWidth'(WakeDelay - 1);
    localparam logic [CntWidth-1:0] IdleLast = CntWidth'(IdleCycles - 1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        ON    = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e              state;
    logic [CntWidth-1:0] cnt;
    logic                act;

    assign act     = req_i | busy_i | force_en_i;
    assign state_o = state;

    // en_o/gnt_o are flops so no decode glitch can reach the gate cell
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= OFF;
            cnt   <= '0;
            en_o  <= 1'b0;
            gnt_o <= 1'b0;
        end else begin
            unique case (state)
                OFF: begin
                    if (act) begin
                        state <= WAKE;
                        cnt   <= '0;
                        en_o  <= 1'b1;
                    end
                end
                WAKE: begin
                    if (cnt == WakeLast) begin
                        state <= ON;
                        cnt   <= '0;
                        gnt_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ON: begin
                    if (act) begin
                        cnt <= '0;
                    end else if (cnt == IdleLast) begin
                        state <= DRAIN;
                        cnt   <= '0;
                        gnt_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    cnt <= '0;
                    if (act) begin
                        state <= ON;
                        gnt_o <= 1'b1;
                    end else begin
                        state <= OFF;
                        en_o  <= 1'b0;
                    end
                end
                default: begin
                    state <= OFF;
                    cnt   <= '0;
                    en_o  <= 1'b0;
                    gnt_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: vector table, corner sequences and random
// stimulus against a countdown/idle-run reference model.
module tb_clk_gate_ctrl;

    localparam int IdleCycles = 4;
    localparam int WakeDelay  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       busy = 1'b0;
    logic       frc = 1'b0;
    logic       en;
    logic       gnt;
    logic [1:0] st;

    int checks = 0;
    int errors = 0;

    // Reference model: phase plus remaining wake cycles and idle run length
    int m_phase;
    int m_wake_left;
    int m_idle_run;

    always #5 clk = ~clk;

    clk_gate_ctrl #(
        .IdleCycles(IdleCycles),
        .WakeDelay (WakeDelay)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .busy_i    (busy),
        .force_en_i(frc),
        .en_o      (en),
        .gnt_o     (gnt),
        .state_o   (st)
    );

    typedef struct {
        logic       r;
        logic       b;
        logic       f;
        logic [1:0] st;
        logic       en;
        logic       gnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_phase     = 0;
        m_wake_left = 0;
        m_idle_run  = 0;
    endtask

    task automatic model_edge(input bit a);
        case (m_phase)
            0: if (a) begin
                m_phase     = 1;
                m_wake_left = WakeDelay;
            end
            1: begin
                m_wake_left--;
                if (m_wake_left == 0) begin
                    m_phase    = 2;
                    m_idle_run = 0;
                end
            end
            2: begin
                m_idle_run = a ? 0 : m_idle_run + 1;
                if (m_idle_run == IdleCycles) m_phase = 3;
            end
            default: begin
                m_phase    = a ? 2 : 0;
                m_idle_run = 0;
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_state"}, int'(st), m_phase);
        chk({tag, "_en"}, int'(en), (m_phase != 0) ? 1 : 0);
        chk({tag, "_gnt"}, int'(gnt), (m_phase == 2) ? 1 : 0);
    endtask

    task automatic step(input logic r, input logic b, input logic f);
        req  = r;
        busy = b;
        frc  = f;
        @(posedge clk);
        model_edge(r | b | f);
        #1;
    endtask

    task automatic add(input logic r, b, f, input logic [1:0] s, input logic e, g);
        vec_t v;
        v.r = r; v.b = b; v.f = f; v.st = s; v.en = e; v.gnt = g;
        vecs.push_back(v);
    endtask

    initial begin
        model_reset();
        // wake, ignore act in WAKE, full timeout, wake via busy
        add(1,0,0, 2'd1, 1, 0);
        add(0,0,0, 2'd1, 1, 0);
        add(0,0,0, 2'd2, 1, 1);
        add(0,0,0, 2'd2, 1, 1);
        add(0,0,0, 2'd2, 1, 1);
        add(0,0,0, 2'd2, 1, 1);
        add(0,0,0, 2'd3, 1, 0);
        add(0,0,0, 2'd0, 0, 0);
        add(0,1,0, 2'd1, 1, 0);
        add(0,1,0, 2'd1, 1, 0);
        add(0,1,0, 2'd2, 1, 1);
        // restart: busy pulse on the 3rd idle cycle
        add(0,0,0, 2'd2, 1, 1);
        add(0,0,0, 2'd2, 1, 1);
        add(0,1,0, 2'd2, 1, 1);
        add(0,0,0, 2'd2, 1, 1);
        add(0,0,0, 2'd2, 1, 1);
        add(0,0,0, 2'd2, 1, 1);
        add(0,0,0, 2'd3, 1, 0);
        // rescue from DRAIN
        add(1,0,0, 2'd2, 1, 1);
        add(0,0,0, 2'd2, 1, 1);

        // T1: async reset visible without an edge, then idle after release
        #12;
        chk("rst_en", int'(en), 0);
        chk("rst_state", int'(st), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            chk("idle_en", int'(en), 0);
            chk("idle_gnt", int'(gnt), 0);
            chk("idle_state", int'(st), 0);
        end

        // T2-T5 table
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].b, vecs[i].f);
            chk($sformatf("vec%0d_state", i), int'(st), int'(vecs[i].st));
            chk($sformatf("vec%0d_en", i), int'(en), int'(vecs[i].en));
            chk($sformatf("vec%0d_gnt", i), int'(gnt), int'(vecs[i].gnt));
            check_model($sformatf("vec%0d_model", i));
        end

        // T6a: force holds the clock on
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 1);
            chk("force_en", int'(en), 1);
            if (i >= WakeDelay) chk("force_state", int'(st), 2);
        end
        for (int i = 0; i < IdleCycles + 2; i++) begin
            step(0, 0, 0);
            check_model("unforce");
        end
        chk("unforce_off", int'(st), 0);

        // T6b: async reset mid-WAKE, between edges
        step(1, 0, 0);
        chk("pre_rst_state", int'(st), 1);
        req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_en", int'(en), 0);
        chk("async_gnt", int'(gnt), 0);
        chk("async_state", int'(st), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random stimulus against the model
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 39) == 0);
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
